// File: rtl/alu_operand_sequencer_if.sv
// Operand/result bus between the sequencer and its producer/ALU/consumer side.
// Optional Chain signal present only when ALU_SEQ_CHAIN_EN is defined.
interface alu_operand_sequencer_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]   Data;
  logic [1:0]     FuncIn;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [1:0]     Function;
  logic [2*N-1:0] ALUout;
  logic [2*N-1:0] Result;
  logic           out_valid;
  logic           out_ready;
`ifdef ALU_SEQ_CHAIN_EN
  logic           Chain;
`endif

  // Producer / ALU / consumer side
  modport master (
`ifdef ALU_SEQ_CHAIN_EN
    output Chain,
`endif
    output Data, FuncIn, in_valid, out_ready, ALUout,
    input  in_ready, A, B, Function, Result, out_valid
  );

  // Sequencer side
  modport slave (
`ifdef ALU_SEQ_CHAIN_EN
    input  Chain,
`endif
    input  Data, FuncIn, in_valid, out_ready, ALUout,
    output in_ready, A, B, Function, Result, out_valid
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer in front of the 4-function ALU: collects A (with function)
// and B one word at a time, captures the ALU result and offers it downstream.
// Optional feature macro: ALU_SEQ_CHAIN_EN (Chain reuses previous Result as B).
module alu_operand_sequencer #(
  parameter int unsigned N = 4
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  alu_operand_sequencer_if.slave bus
);

  localparam int unsigned RW = 2 * N;

  localparam logic [1:0] GET_A = 2'd0;
  localparam logic [1:0] GET_B = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [N-1:0]  a_q, a_nxt;
  logic [N-1:0]  b_q, b_nxt;
  logic [1:0]    func_q, func_nxt;
  logic [RW-1:0] result_q, result_nxt;
  logic          out_valid_q, out_valid_nxt;
  logic          in_ready_q, in_ready_nxt;

  // State register plus all registered outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= GET_A;
      a_q         <= '0;
      b_q         <= '0;
      func_q      <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state       <= state_nxt;
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      func_q      <= func_nxt;
      result_q    <= result_nxt;
      out_valid_q <= out_valid_nxt;
      in_ready_q  <= in_ready_nxt;
    end
  end

  // Next-state and next-output decode; in_ready is derived from the next state
  // so the registered copy always matches the state it is presented in.
  always_comb begin
    state_nxt     = state;
    a_nxt         = a_q;
    b_nxt         = b_q;
    func_nxt      = func_q;
    result_nxt    = result_q;
    out_valid_nxt = out_valid_q;
    case (state)
      GET_A: begin
        if (bus.in_valid) begin
          a_nxt     = bus.Data;
          func_nxt  = bus.FuncIn;
          state_nxt = GET_B;
`ifdef ALU_SEQ_CHAIN_EN
          if (bus.Chain) begin
            b_nxt     = result_q[N-1:0];
            state_nxt = EXEC;
          end
`endif
        end
      end
      GET_B: begin
        if (bus.in_valid) begin
          b_nxt     = bus.Data;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        result_nxt    = bus.ALUout;
        out_valid_nxt = 1'b1;
        state_nxt     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = GET_A;
        end
      end
      default: state_nxt = GET_A;
    endcase
    in_ready_nxt = (state_nxt == GET_A) || (state_nxt == GET_B);
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.Function  = func_q;
  assign bus.Result    = result_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural part3 ALU model.
// Chain scenario adapts to ALU_SEQ_CHAIN_EN.
module tb_alu_operand_sequencer;

  localparam int unsigned N = 4;

  logic Clock;
  logic Resetn;
  int   n_vec;
  int   n_err;

  alu_operand_sequencer_if #(.N(N)) bus ();

  alu_operand_sequencer #(.N(N)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  // Behavioural part3 ALU: add, reduction-OR, reduction-AND, concatenate
  always_comb begin
    case (bus.Function)
      2'd0:    bus.ALUout = 8'(bus.A) + 8'(bus.B);
      2'd1:    bus.ALUout = {7'd0, |{bus.A, bus.B}};
      2'd2:    bus.ALUout = {7'd0, &{bus.A, bus.B}};
      default: bus.ALUout = {bus.A, bus.B};
    endcase
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Two-word operation with out_ready already high; starts and ends in GET_A
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f,
                       input logic [7:0] exp, input string tag);
    bus.Data = a; bus.FuncIn = f; bus.in_valid = 1'b1;
    tick();
    bus.Data = b; bus.FuncIn = ~f;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check({tag, "_result"}, 32'(bus.Result), 32'(exp));
    check({tag, "_func"}, 32'(bus.Function), 32'(f));
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Resetn = 1'b0;
    bus.Data = '0; bus.FuncIn = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    bus.Chain = 1'b0;
`endif
    repeat (2) @(posedge Clock);
    #1;
    check("rst_A", 32'(bus.A), 32'h0);
    check("rst_B", 32'(bus.B), 32'h0);
    check("rst_func", 32'(bus.Function), 32'h0);
    check("rst_result", 32'(bus.Result), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    Resetn = 1'b1;

    // Add 3+5 on the first edge after reset release
    bus.out_ready = 1'b1;
    bus.Data = 4'd3; bus.FuncIn = 2'd0; bus.in_valid = 1'b1;
    tick();
    check("add_A", 32'(bus.A), 32'h3);
    check("add_in_ready_getb", 32'(bus.in_ready), 32'h1);
    bus.Data = 4'd5; bus.FuncIn = 2'd3;
    tick();
    check("add_B", 32'(bus.B), 32'h5);
    check("add_in_ready_exec", 32'(bus.in_ready), 32'h0);
    check("add_valid_exec", 32'(bus.out_valid), 32'h0);
    bus.in_valid = 1'b0;
    tick();
    check("add_valid", 32'(bus.out_valid), 32'h1);
    check("add_result", 32'(bus.Result), 32'h08);
    check("add_in_ready_done", 32'(bus.in_ready), 32'h0);
    tick();
    check("add_valid_drop", 32'(bus.out_valid), 32'h0);
    check("add_in_ready_back", 32'(bus.in_ready), 32'h1);
    check("add_result_kept", 32'(bus.Result), 32'h08);

    // Concatenate and reductions
    do_op(4'hA, 4'h5, 2'd3, 8'hA5, "concat");
    do_op(4'h0, 4'h0, 2'd1, 8'h00, "or0");
    do_op(4'h8, 4'h0, 2'd1, 8'h01, "or1");
    do_op(4'hF, 4'hF, 2'd2, 8'h01, "andF");
    do_op(4'hF, 4'hE, 2'd2, 8'h00, "and0");
    do_op(4'hF, 4'hF, 2'd0, 8'h1E, "addmax");

    // Backpressure: consumer stalls, producer offers a word during DONE
    bus.out_ready = 1'b0;
    bus.Data = 4'd1; bus.FuncIn = 2'd0; bus.in_valid = 1'b1;
    tick();
    bus.Data = 4'd2;
    tick();
    bus.Data = 4'd9;
    tick();
    check("bp_valid", 32'(bus.out_valid), 32'h1);
    check("bp_result", 32'(bus.Result), 32'h03);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_result", 32'(bus.Result), 32'h03);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'h0);
      check("bp_hold_valid", 32'(bus.out_valid), 32'h1);
      check("bp_hold_A", 32'(bus.A), 32'h1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(bus.out_valid), 32'h0);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'h1);
    check("bp_release_A", 32'(bus.A), 32'h1);
    tick();
    check("bp_next_A", 32'(bus.A), 32'h9);
    bus.Data = 4'd0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("bp_next_result", 32'(bus.Result), 32'h09);
    tick();

    // Input stalls between A and B
    bus.Data = 4'd6; bus.FuncIn = 2'd3; bus.in_valid = 1'b1;
    tick();
    check("stall_A", 32'(bus.A), 32'h6);
    bus.Data = 4'hF; bus.in_valid = 1'b0;
    tick();
    check("stall_B_hold1", 32'(bus.B), 32'h0);
    check("stall_in_ready", 32'(bus.in_ready), 32'h1);
    bus.Data = 4'hE;
    tick();
    check("stall_B_hold2", 32'(bus.B), 32'h0);
    bus.Data = 4'd2; bus.in_valid = 1'b1;
    tick();
    check("stall_B", 32'(bus.B), 32'h2);
    bus.in_valid = 1'b0;
    tick();
    check("stall_result", 32'(bus.Result), 32'h62);
    check("stall_valid", 32'(bus.out_valid), 32'h1);
    tick();

    // Asynchronous reset while waiting for B
    bus.Data = 4'd7; bus.FuncIn = 2'd1; bus.in_valid = 1'b1;
    tick();
    check("mid_A", 32'(bus.A), 32'h7);
    bus.in_valid = 1'b0;
    Resetn = 1'b0;
    #1;
    check("mid_rst_A", 32'(bus.A), 32'h0);
    check("mid_rst_B", 32'(bus.B), 32'h0);
    check("mid_rst_func", 32'(bus.Function), 32'h0);
    check("mid_rst_result", 32'(bus.Result), 32'h0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
    Resetn = 1'b1;
    do_op(4'd2, 4'd2, 2'd0, 8'h04, "post_rst");

    // Chain: previous result low bits become B when enabled
    do_op(4'd3, 4'd5, 2'd0, 8'h08, "pre_chain");
`ifdef ALU_SEQ_CHAIN_EN
    bus.Chain = 1'b1;
`endif
    bus.Data = 4'd1; bus.FuncIn = 2'd0; bus.in_valid = 1'b1;
    tick();
`ifdef ALU_SEQ_CHAIN_EN
    bus.Chain = 1'b0;
    bus.in_valid = 1'b0;
    check("chain_B", 32'(bus.B), 32'h8);
    check("chain_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
`else
    check("nochain_in_ready", 32'(bus.in_ready), 32'h1);
    bus.Data = 4'd8;
    tick();
    bus.in_valid = 1'b0;
    tick();
`endif
    check("chain_valid", 32'(bus.out_valid), 32'h1);
    check("chain_result", 32'(bus.Result), 32'h09);
    tick();
    check("chain_done", 32'(bus.out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end stage for the 4-function combinational ALU (`part3`: add, reduction-OR, reduction-AND, concatenate). It accepts operands one at a time over a narrow valid/ready input and presents registered `A`, `B` and `Function` to the ALU. It then captures the ALU's `2N`-bit result into an output register and offers it downstream on a valid/ready handshake. One operation is in flight at a time.

## Interface
- `N`, default 4: operand width; must match the ALU's `N`.

- `Clock`  in  1: rising-edge clock.
- `Resetn`  in  1: asynchronous, active-low reset.
- `Data`  in  N: operand word (A first, then B).
- `FuncIn`  in  2: ALU function; sampled only with the A word.
- `in_valid`  in  1: `Data`/`FuncIn` valid.
- `in_ready`  out  1: sequencer can accept a word.
- `A`  out  N: registered operand A to the ALU.
- `B`  out  N: registered operand B to the ALU.
- `Function`  out  2: registered function select to the ALU.
- `ALUout`  in  2N: combinational result from the ALU.
- `Result`  out  2N: registered result.
- `out_valid`  out  1: `Result` holds an unconsumed result.
- `out_ready`  in  1: downstream accepts `Result`.
- `Chain`  in  1: chain request; exists only when `ALU_SEQ_CHAIN_EN` is defined.

## Operation
- States are `GET_A`, `GET_B`, `EXEC` and `DONE`. Reset enters `GET_A`.
- **`GET_A`**
  - `in_ready=1`.
  - On `in_valid`: `A<=Data`, `Function<=FuncIn`, go to `GET_B`.
- **`GET_B`**
  - `in_ready=1`.
  - On `in_valid`: `B<=Data`, go to `EXEC`.
- **`EXEC`**
  - `in_ready=0`.
  - Unconditionally `Result<=ALUout`, `out_valid<=1`, go to `DONE`.
- **`DONE`**
  - `in_ready=0`.
  - On `out_ready`: `out_valid<=0`, go to `GET_A`.
  - `Result` is retained after consumption (not cleared).
- `in_ready` is a pure function of state (Moore); it never depends on `in_valid`.
- `A`, `B` and `Function` change only on accepted transfers. They are stable from `EXEC` through `DONE`.
- `ALUout` is captured verbatim at full `2N` width. No truncation or extension is applied; A+B always fits in `2N`.
- A word offered while `in_ready=0` is neither consumed nor lost. It must be held by the producer.
- **Asynchronous `Resetn` low**, at any time including mid-operation:
  - state goes to `GET_A`.
  - `A`, `B`, `Function` and `Result` go to 0.
  - `out_valid` goes to 0; `in_ready` reads 1 after reset.
  - Partial operands are discarded.

## Timing
- One word is accepted per cycle, at most.
- A is accepted on edge k, and B on edge ≥k+1.
- B accepted on edge m: `EXEC` occupies cycle m→m+1, and `Result`/`out_valid` are valid after edge m+1.
- Minimum initiation interval is 4 cycles: A, B, EXEC, plus DONE with `out_ready` already high.
- `out_valid` drops on the edge where `out_valid&&out_ready`. `in_ready` rises in the same cycle.
- Reset release: the first A can be accepted on the first rising edge with `Resetn` high.

## Configuration
- **`ALU_SEQ_CHAIN_EN` defined:**
  - Adds the `Chain` port.
  - In `GET_A`, an accepted word with `Chain=1` also loads `B<=Result[N-1:0]` (previous result, low bits) and goes directly to `EXEC`, skipping `GET_B`.
  - Chained latency from A acceptance to `out_valid` is 2 edges.
  - `Chain` is ignored outside `GET_A`.
- **`ALU_SEQ_CHAIN_EN` undefined:** no `Chain` port; every operation takes the two-word path.

## Test plan
N=4 throughout.
- **Add:** A=3 with `FuncIn`=0, then B=5, `out_ready`=1 → `Result`=8'h08; `out_valid` high exactly 1 cycle, 2 edges after B accepted.
- **Concatenate and reductions:**
  - `FuncIn`=3, A=4'hA, B=4'h5 → 8'hA5.
  - `FuncIn`=1, A=0, B=0 → 8'h00.
  - `FuncIn`=2, A=4'hF, B=4'hF → 8'h01.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` → `Result` stable and `in_ready`=0 throughout. Offered `Data` is not consumed; the next A is accepted the cycle after `out_ready` goes high.
- **Input stalls:** `in_valid` toggled 1-0-0-1 across A and B → operands captured only on valid cycles; `Result` is correct.
- **Reset mid-operation:** assert `Resetn`=0 in `GET_B` after A=7 → all outputs 0 and `in_ready`=1. A subsequent 2+2 (`FuncIn`=0) yields 8'h04; no stale A.
- **Chain, with `ALU_SEQ_CHAIN_EN`:**
  - 3+5=8'h08, then A=1 with `Chain`=1 and `FuncIn`=0 → `Result`=8'h09, 2 edges after A.
  - Without the macro, the same run requires B and no `Chain` port exists.
